axi_addr_queue: RTL
===================

# axi_addr_queue

Parametrised AXI address-channel queue for the AXI-to-APB bridge slave core. It buffers AW or AR beats (address, ID, LEN, SIZE, BURST, PROT) between the AXI slave handshake and the address generator. It uses valid/ready on both sides, first-word-fall-through output, an occupancy count, an almost-full flag and a synchronous flush. One instance serves either the write or the read address channel.

## Interface
Parameters:
- ADDR_W, 32, address width (≥12)
- ID_W, 6, transaction ID width
- DEPTH_LOG2, 3, log2 of entry count (DEPTH = 2^DEPTH_LOG2)
- AFULL_THRESH, 6, almost_full asserts when count ≥ this value (1..DEPTH)

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-low
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous clear of all entries
- s_valid / s_ready  in / out  1  push handshake
- s_addr, s_id, s_len, s_size, s_burst, s_prot  in  ADDR_W, ID_W, 8, 3, 2, 3  push payload
- m_valid / m_ready  out / in  1  pop handshake
- m_addr, m_id, m_len, m_size, m_burst, m_prot  out  same widths  head payload
- m_err  out  1  head burst crosses a 4 KB boundary (see Configuration)
- count  out  DEPTH_LOG2+1  current occupancy
- almost_full  out  1  count ≥ AFULL_THRESH
- empty  out  1  count == 0

## Operation
- Storage is DEPTH entries. wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide, with the MSB as the wrap bit. Full = pointers equal except the MSB. Empty = pointers fully equal.
- Push occurs when s_valid && s_ready. s_ready = !full. A push is refused when full, even if a pop happens in the same cycle. There is no full pass-through.
- Pop occurs when m_valid && m_ready. m_valid = !empty.
- m_* show the entry at rd_ptr combinationally. All m_* payload outputs are forced to 0 when empty, so X values never propagate.
- count changes as follows:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- The pointers increment modulo 2^(DEPTH_LOG2+1).
- flush sets both pointers and count to 0 on the next edge. flush takes priority over push and pop in the same cycle; the pushed beat is discarded.
- An AXI beat is never lost or duplicated. Output order equals input order.
- Payload is stored exactly as presented. The queue does not interpret BURST or LEN, except for the m_err computation.

## Timing
- Reset values:
  - pointers 0, count 0
  - empty 1, m_valid 0, s_ready 1, almost_full 0
  - all m_* 0, m_err 0
- Reset is asynchronous and takes effect immediately, including mid-operation. All entries are discarded.
- Latency: a beat pushed at edge N is visible on m_* with m_valid = 1 in the cycle after edge N.
- s_ready, m_valid, empty, almost_full and count are registered-state derived. They do not depend combinationally on s_valid or m_ready.
- Throughput is one push and one pop per cycle.
- Wrap-around: after the pointer MSB toggles, full and empty detection and ordering remain correct.

## Configuration
- Macro: AXI_ADDR_QUEUE_4K_CHECK_EN.
- Defined:
  - At push, compute end = s_addr[11:0] + ((s_len+1) << s_size) with 17-bit unsigned arithmetic.
  - The crossing bit is 1 when s_burst == 2'b01 (INCR) and end > 4096. It is 0 for FIXED and WRAP.
  - The bit is stored with the entry and presented on m_err with the head payload.
- Undefined: no extra storage bit is kept, and m_err is tied to 0.

## Test plan
- Reset and fill: with DEPTH_LOG2=3, push 8 beats, addr = 0x100·i. Required: count = 8, s_ready = 0, almost_full = 1 from count 6. A 9th push with m_ready = 0 is refused. Popping returns 0x000..0x700 in order.
- Simultaneous: at count 3, hold s_valid = m_ready = 1 for 5 cycles. Required: count stays 3, and the popped IDs are the 5 oldest.
- Wrap: stream 20 beats, ID = i, with random m_ready stalls. Required: IDs emerge 0..19 in order, with no loss after both pointers wrap.
- 4K check (macro on), all INCR:
  - addr 0x0FF0, len 3, size 2 → m_err = 0 (end 4096)
  - addr 0x0FF4, same len and size → m_err = 1
  - WRAP at addr 0x0FF4 → m_err = 0
- Flush: at count 5, assert flush together with a push. Required: next cycle count = 0, empty = 1, and the pushed beat is absent.
- Async reset: drop reset mid-burst, with no clock edge. Required: m_valid = 0 and count = 0 immediately, and all outputs hold their reset values.

Source files
------------

// File: rtl/axi_addr_queue.sv
// axi_addr_queue
// AXI address-channel queue (AW or AR) between the slave handshake and the
// address generator. It is first-word-fall-through: the head entry appears on
// the m_* outputs combinationally, and those outputs are zeroed while empty.
// It also provides an occupancy count, an almost-full flag and a synchronous
// flush.
//
// Optional feature macro: AXI_ADDR_QUEUE_4K_CHECK_EN
//   When defined, each INCR beat is tagged at push time with whether its burst
//   runs past the 4 KB page that contains its start address. The tag is
//   presented on m_err together with the head entry.
//   When undefined, no tag storage exists and m_err is tied to 0.

module axi_addr_queue #(
  parameter int ADDR_W       = 32,
  parameter int ID_W         = 6,
  parameter int DEPTH_LOG2   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,

  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [ID_W-1:0]       s_id,
  input  logic [7:0]            s_len,
  input  logic [2:0]            s_size,
  input  logic [1:0]            s_burst,
  input  logic [2:0]            s_prot,

  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [ID_W-1:0]       m_id,
  output logic [7:0]            m_len,
  output logic [2:0]            m_size,
  output logic [1:0]            m_burst,
  output logic [2:0]            m_prot,
  output logic                  m_err,

  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  empty
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] WRAP_DIFF = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  full;
  logic                  push;
  logic                  pop;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [ID_W-1:0]   id_mem    [DEPTH];
  logic [7:0]        len_mem   [DEPTH];
  logic [2:0]        size_mem  [DEPTH];
  logic [1:0]        burst_mem [DEPTH];
  logic [2:0]        prot_mem  [DEPTH];

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // Full/empty/count come only from the pointers, so the handshake flags never
  // depend combinationally on s_valid or m_ready.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = ((wr_ptr ^ rd_ptr) == WRAP_DIFF);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AFULL_CNT);
  assign s_ready     = !full;
  assign m_valid     = !empty;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // Pointer update: async reset, flush wins over push/pop, modulo 2*DEPTH wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Payload storage: written only on an accepted, non-flushed push.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem[wr_idx]  <= s_addr;
      id_mem[wr_idx]    <= s_id;
      len_mem[wr_idx]   <= s_len;
      size_mem[wr_idx]  <= s_size;
      burst_mem[wr_idx] <= s_burst;
      prot_mem[wr_idx]  <= s_prot;
    end
  end

  assign m_addr  = empty ? '0 : addr_mem[rd_idx];
  assign m_id    = empty ? '0 : id_mem[rd_idx];
  assign m_len   = empty ? '0 : len_mem[rd_idx];
  assign m_size  = empty ? '0 : size_mem[rd_idx];
  assign m_burst = empty ? '0 : burst_mem[rd_idx];
  assign m_prot  = empty ? '0 : prot_mem[rd_idx];

`ifdef AXI_ADDR_QUEUE_4K_CHECK_EN
  logic        err_mem [DEPTH];
  logic [16:0] beat_cnt;
  logic [16:0] burst_bytes;
  logic [16:0] burst_end;
  logic        s_cross;

  // Page-crossing detect: end offset = page offset + (len+1) << size, 17 bits.
  always_comb begin
    beat_cnt    = {9'd0, s_len} + 17'd1;
    burst_bytes = beat_cnt << s_size;
    burst_end   = {5'd0, s_addr[11:0]} + burst_bytes;
    s_cross     = (s_burst == 2'b01) && (burst_end > 17'd4096);
  end

  // The crossing tag travels with its entry.
  always_ff @(posedge clk) begin
    if (push && !flush) err_mem[wr_idx] <= s_cross;
  end

  assign m_err = !empty && err_mem[rd_idx];
`else
  assign m_err = 1'b0;
`endif

endmodule
